input_debouncer: RTL

Multi-channel synchronizer and debouncer for raw asynchronous inputs such as buttons, switches and slow external strobes. It sits directly upstream of the edge detector. It turns bouncing, clock-asynchronous levels into clean, clock-synchronous levels that change at most once per debounce window. The edge detector then converts those levels into single-cycle pulses.

---
 rtl/input_debouncer_pkg.sv | 20 ++
 rtl/input_debouncer_channel.sv | 69 ++++++
 rtl/input_debouncer.sv | 49 ++++
 3 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared types and width helper for the multi-channel input debouncer.
// Imported by the channel sub-module and by the top.
package input_debouncer_pkg;

    typedef enum logic {
        CH_IDLE    = 1'b0,
        CH_PENDING = 1'b1
    } ch_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounce lane: two-flop synchronizer, stability counter and
// registered output level.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int   STABLE_TICKS = 16,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_out,
    output logic o_busy
);

    localparam int               CNT_W    = clog2_min1(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    ch_state_e        w_state;
    logic             w_out_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1  <= RESET_LEVEL;
            r_s2  <= RESET_LEVEL;
            r_out <= RESET_LEVEL;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_raw;
            r_s2  <= r_s1;
            r_out <= w_out_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign w_state = (r_s2 != r_out) ? CH_PENDING : CH_IDLE;

    // A return to the current level on any cycle restarts the count.
    always_comb begin
        w_out_nxt = r_out;
        w_cnt_nxt = r_cnt;
        unique case (w_state)
            CH_IDLE: begin
                w_cnt_nxt = '0;
            end
            CH_PENDING: begin
                if (i_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_out_nxt = r_s2;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    assign o_out  = r_out;
    assign o_busy = (w_state == CH_PENDING) || (r_cnt != '0);

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel synchronizer/debouncer: shared sample prescaler feeding
// WIDTH independent debounce lanes.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int   WIDTH        = 1,
    parameter int   PRESCALE     = 1000,
    parameter int   STABLE_TICKS = 16,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] iv_input,
    output logic [WIDTH-1:0] ov_output,
    output logic [WIDTH-1:0] ov_busy
);

    localparam int              PS_W    = clog2_min1(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_ps;
    logic            w_tick;

    // With PRESCALE=1 the counter sits at zero and every cycle ticks.
    assign w_tick = (r_ps == PS_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ps <= '0;
        end else begin
            r_ps <= w_tick ? '0 : r_ps + PS_W'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_tick (w_tick),
            .i_raw  (iv_input[g]),
            .o_out  (ov_output[g]),
            .o_busy (ov_busy[g])
        );
    end

endmodule
